// File: rtl/ofdm_rx_pkg.sv
// Shared types and constants for the OFDM receive frame sequencer.
package ofdm_rx_pkg;

  localparam int SYM_CNT_W = 8;
  localparam int STAT_W    = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEARCH  = 3'd1,
    SYNC_B  = 3'd2,
    RECEIVE = 3'd3,
    FLUSH   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/ofdm_rx_frame_ctrl_if.sv
// Sample path between the rx FIFO read side, the frame sequencer and the receiver.
interface ofdm_rx_frame_ctrl_if #(
  parameter int DATA_SIZE = 16
);
  logic                   i_fifo_empty;
  logic [2*DATA_SIZE-1:0] i_fifo_dout;
  logic                   o_fifo_rd_en;
  logic                   i_rx_wait_data;
  logic                   o_rx_valid;
  logic [DATA_SIZE-1:0]   o_rx_data_i;
  logic [DATA_SIZE-1:0]   o_rx_data_q;

  modport master (
    input  i_fifo_empty, i_fifo_dout, i_rx_wait_data,
    output o_fifo_rd_en, o_rx_valid, o_rx_data_i, o_rx_data_q
  );

  modport slave (
    output i_fifo_empty, i_fifo_dout, i_rx_wait_data,
    input  o_fifo_rd_en, o_rx_valid, o_rx_data_i, o_rx_data_q
  );
endinterface

// File: rtl/ofdm_rx_watchdog.sv
// Cycle watchdog: clears on demand, counts while enabled, flags expiry at TIMEOUT-1.
module ofdm_rx_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (cnt == LIMIT);

endmodule

// File: rtl/ofdm_rx_frame_ctrl.sv
// OFDM receive frame sequencer: FIFO read gating, preamble tracking, symbol count, watchdog, flush.
// Optional frame/timeout statistics are compiled in with OFDM_RX_CTRL_STATS_EN.
module ofdm_rx_frame_ctrl
  import ofdm_rx_pkg::*;
#(
  parameter int DATA_SIZE    = 16,
  parameter int FFT_SIZE     = 64,
  parameter int TIMEOUT      = 4096,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_en,
  input  logic [SYM_CNT_W-1:0] i_num_symbols,
  ofdm_rx_frame_ctrl_if.master rx,
  input  logic                 i_find_preamble_a,
  input  logic                 i_find_preamble_b,
  input  logic                 i_fft_valid,
  output logic                 o_rx_reset,
  output logic                 o_frame_start,
  output logic                 o_frame_done,
  output logic                 o_timeout,
  output logic [2:0]           o_state,
  output logic [SYM_CNT_W-1:0] o_symbol_cnt,
  output logic [STAT_W-1:0]    o_frame_cnt,
  output logic [STAT_W-1:0]    o_timeout_cnt
);
  localparam int SMP_W = (FFT_SIZE > 2) ? $clog2(FFT_SIZE) : 1;
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(FFT_SIZE - 1);
  localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_CYCLES - 1);

  function automatic logic [SYM_CNT_W-1:0] sym_inc(input logic [SYM_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  rx_state_t            state, state_nxt;
  logic [SYM_CNT_W-1:0] num_lat;
  logic [SMP_W-1:0]     smp_cnt;
  logic [SYM_CNT_W-1:0] sym_cnt;
  logic [FL_W-1:0]      flush_cnt;
  logic                 latch_num;
  logic                 wd_en, wd_clr, wd_expire;
  logic                 smp_wrap, sym_done;
  logic                 rd_en_p0, vld_p1;
  logic                 frame_start, frame_done, timeout_p;

  // p0: read request, gated on an active state and a ready receiver
  assign rd_en_p0 = i_en && !rx.i_fifo_empty && rx.i_rx_wait_data &&
                    ((state == SEARCH) || (state == SYNC_B) || (state == RECEIVE));
  assign rx.o_fifo_rd_en = rd_en_p0;

  // p1: FIFO data arrives one cycle after the read; valid follows it
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) vld_p1 <= 1'b0;
    else            vld_p1 <= rd_en_p0;
  end

  assign rx.o_rx_valid  = vld_p1;
  assign rx.o_rx_data_i = rx.i_fifo_dout[DATA_SIZE-1:0];
  assign rx.o_rx_data_q = rx.i_fifo_dout[2*DATA_SIZE-1:DATA_SIZE];

  assign wd_en  = (state == SYNC_B) || (state == RECEIVE);
  assign wd_clr = !wd_en ||
                  ((state == SYNC_B) && (i_find_preamble_a || i_find_preamble_b)) ||
                  ((state == RECEIVE) && i_fft_valid);

  ofdm_rx_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (wd_clr),
    .i_en      (wd_en),
    .o_expire  (wd_expire)
  );

  assign smp_wrap = (smp_cnt == SMP_LAST);
  assign sym_done = i_fft_valid && smp_wrap && (num_lat != '0) &&
                    (sym_inc(sym_cnt) == num_lat);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    latch_num   = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    timeout_p   = 1'b0;
    case (state)
      IDLE: begin
        if (i_en) begin
          state_nxt = SEARCH;
          latch_num = 1'b1;
        end
      end
      SEARCH: begin
        if (!i_en) begin
          state_nxt = FLUSH;
        end else if (i_find_preamble_a && i_find_preamble_b) begin
          state_nxt   = RECEIVE;
          frame_start = 1'b1;
        end else if (i_find_preamble_a) begin
          state_nxt = SYNC_B;
        end
      end
      SYNC_B: begin
        if (!i_en) begin
          state_nxt = FLUSH;
        end else if (i_find_preamble_b) begin
          state_nxt   = RECEIVE;
          frame_start = 1'b1;
        end else if (!i_find_preamble_a && wd_expire) begin
          state_nxt = FLUSH;
          timeout_p = 1'b1;
        end
      end
      RECEIVE: begin
        if (!i_en) begin
          state_nxt = FLUSH;
        end else if (sym_done) begin
          state_nxt  = FLUSH;
          frame_done = 1'b1;
        end else if (!i_fft_valid && wd_expire) begin
          state_nxt = FLUSH;
          timeout_p = 1'b1;
        end
      end
      FLUSH: begin
        if (flush_cnt == FL_LAST) begin
          if (i_en) begin
            state_nxt = SEARCH;
            latch_num = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      num_lat <= '0;
    end else if (latch_num) begin
      num_lat <= i_num_symbols;
    end
  end

  // Counters only live in RECEIVE; the final count stays visible for the first FLUSH cycle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      smp_cnt <= '0;
      sym_cnt <= '0;
    end else if (state != RECEIVE) begin
      smp_cnt <= '0;
      sym_cnt <= '0;
    end else if (i_fft_valid) begin
      smp_cnt <= smp_wrap ? '0 : smp_cnt + 1'b1;
      if (smp_wrap) sym_cnt <= sym_inc(sym_cnt);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)              flush_cnt <= '0;
    else if (state != FLUSH)     flush_cnt <= '0;
    else if (flush_cnt != FL_LAST) flush_cnt <= flush_cnt + 1'b1;
  end

  assign o_rx_reset    = (state == IDLE) || (state == FLUSH);
  assign o_frame_start = frame_start;
  assign o_frame_done  = frame_done;
  assign o_timeout     = timeout_p;
  assign o_state       = state;
  assign o_symbol_cnt  = sym_cnt;

`ifdef OFDM_RX_CTRL_STATS_EN
  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [STAT_W-1:0] frame_cnt, timeout_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      frame_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      if (frame_done) frame_cnt   <= stat_inc(frame_cnt);
      if (timeout_p)  timeout_cnt <= stat_inc(timeout_cnt);
    end
  end

  assign o_frame_cnt   = frame_cnt;
  assign o_timeout_cnt = timeout_cnt;
`else
  assign o_frame_cnt   = '0;
  assign o_timeout_cnt = '0;
`endif

endmodule
